// File: rtl/call_return_ctrl_if.sv
// Decoder/datapath-side bundle for the call/return sequencer.
// The controller takes the slave side; the PC/stack side is the master.
interface call_return_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 16
);
  localparam int DW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] pc_cur;
  logic              call_req;
  logic [ADDR_W-1:0] call_target;
  logic              ret_req;
  logic              retfie_req;
  logic              irq;
  logic              stall;
  logic              gie_wr;
  logic              gie_wdata;
  logic              clr_flags;
  logic [ADDR_W-1:0] stack_top;
  logic              stk_push;
  logic              stk_pop;
  logic [ADDR_W-1:0] stk_data;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_next;
  logic              gie;
  logic [DW-1:0]     depth;
  logic              overflow;
  logic              underflow;
  logic              busy;

  modport master (
    output pc_cur, call_req, call_target, ret_req, retfie_req,
    output irq, stall, gie_wr, gie_wdata, clr_flags, stack_top,
    input  stk_push, stk_pop, stk_data, pc_load, pc_next,
    input  gie, depth, overflow, underflow, busy
  );

  modport slave (
    input  pc_cur, call_req, call_target, ret_req, retfie_req,
    input  irq, stall, gie_wr, gie_wdata, clr_flags, stack_top,
    output stk_push, stk_pop, stk_data, pc_load, pc_next,
    output gie, depth, overflow, underflow, busy
  );
endinterface

// File: rtl/call_return_ctrl.sv
// Return-address stack sequencer: CALL/RETURN/RETFIE/IRQ entry, GIE, depth.
// Optional STACK_CTRL_TRAP_EN: stack faults redirect to TRAP_VECTOR instead.
module call_return_ctrl #(
  parameter int              ADDR_W      = 11,
  parameter int              DEPTH       = 16,
  parameter logic [ADDR_W-1:0] INT_VECTOR  = 11'h004,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR = 11'h7FF
) (
  input logic               clk,
  input logic               reset,
  call_return_ctrl_if.slave bus
);
  localparam int DW = $clog2(DEPTH) + 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t            state_q, state_d;
  logic              push_q, push_d;
  logic              pop_q, pop_d;
  logic [ADDR_W-1:0] data_q, data_d;
  logic              load_q, load_d;
  logic [ADDR_W-1:0] pcn_q, pcn_d;
  logic              gie_q, gie_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              busy_q, busy_d;

  logic              sel_int, sel_call, sel_rfie, sel_ret;
  logic              do_push, do_pop;
  logic [ADDR_W-1:0] push_val, tgt;
  logic              full, empty;

  assign sel_int  = bus.irq & gie_q;
  assign sel_call = bus.call_req & ~sel_int;
  assign sel_rfie = bus.retfie_req & ~sel_int & ~bus.call_req;
  assign sel_ret  = bus.ret_req & ~sel_int & ~bus.call_req
                  & ~bus.retfie_req;
  assign full     = (depth_q == DW'(DEPTH));
  assign empty    = (depth_q == '0);

`ifndef STACK_CTRL_TRAP_EN
  logic unused_trap;
  assign unused_trap = ^TRAP_VECTOR;
`endif

  // Arbitrate one event per idle cycle and form next registered outputs
  always_comb begin
    state_d  = state_q;
    push_d   = 1'b0;
    pop_d    = 1'b0;
    data_d   = '0;
    load_d   = 1'b0;
    pcn_d    = '0;
    busy_d   = 1'b0;
    depth_d  = depth_q;
    gie_d    = bus.gie_wr ? bus.gie_wdata : gie_q;
    ovf_d    = ovf_q & ~bus.clr_flags;
    udf_d    = udf_q & ~bus.clr_flags;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    push_val = '0;
    tgt      = '0;
    if (state_q == FLUSH) begin
      state_d = IDLE;
    end else if (!bus.stall) begin
      unique case (1'b1)
        sel_int: begin
          do_push  = 1'b1;
          push_val = bus.pc_cur;
          tgt      = INT_VECTOR;
          gie_d    = 1'b0;
        end
        sel_call: begin
          do_push  = 1'b1;
          push_val = bus.pc_cur + ADDR_W'(1);
          tgt      = bus.call_target;
        end
        sel_rfie: begin
          do_pop = 1'b1;
          tgt    = bus.stack_top;
          gie_d  = 1'b1;
        end
        sel_ret: begin
          do_pop = 1'b1;
          tgt    = bus.stack_top;
        end
        default: ;
      endcase
    end
    if (do_push || do_pop) begin
      state_d = FLUSH;
      busy_d  = 1'b1;
      load_d  = 1'b1;
      pcn_d   = tgt;
    end
    if (do_push) begin
      if (full) begin
        ovf_d = 1'b1;
`ifdef STACK_CTRL_TRAP_EN
        pcn_d = TRAP_VECTOR;
        gie_d = 1'b0;
`else
        push_d = 1'b1;
        data_d = push_val;
`endif
      end else begin
        push_d  = 1'b1;
        data_d  = push_val;
        depth_d = depth_q + DW'(1);
      end
    end
    if (do_pop) begin
      if (empty) begin
        udf_d = 1'b1;
`ifdef STACK_CTRL_TRAP_EN
        pcn_d = TRAP_VECTOR;
        gie_d = 1'b0;
`else
        pop_d = 1'b1;
`endif
      end else begin
        pop_d   = 1'b1;
        depth_d = depth_q - DW'(1);
      end
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      data_q  <= '0;
      load_q  <= 1'b0;
      pcn_q   <= '0;
      gie_q   <= 1'b0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      data_q  <= data_d;
      load_q  <= load_d;
      pcn_q   <= pcn_d;
      gie_q   <= gie_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.stk_push  = push_q;
  assign bus.stk_pop   = pop_q;
  assign bus.stk_data  = data_q;
  assign bus.pc_load   = load_q;
  assign bus.pc_next   = pcn_q;
  assign bus.gie       = gie_q;
  assign bus.depth     = depth_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_call_return_ctrl.sv
// Scoreboard bench for call_return_ctrl: directed events queue expected
// redirects; a negedge monitor pops and compares each pc_load cycle.
module tb_call_return_ctrl;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  call_return_ctrl_if #(.ADDR_W(11), .DEPTH(16)) bus ();

  call_return_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic        push;
    logic        pop;
    logic [10:0] data;
    logic [10:0] pcn;
    logic [4:0]  depth;
    logic        gie;
    logic        ovf;
    logic        udf;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  int   d  = 0;
  logic g  = 1'b0;
  logic ov = 1'b0;
  logic un = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.call_req   = 1'b0;
    bus.ret_req    = 1'b0;
    bus.retfie_req = 1'b0;
    bus.irq        = 1'b0;
    bus.stall      = 1'b0;
    bus.gie_wr     = 1'b0;
    bus.gie_wdata  = 1'b0;
    bus.clr_flags  = 1'b0;
  endtask

  task automatic m_push(input logic [10:0] val, input logic [10:0] tgt,
                        input logic irqent);
    exp_t e;
    e = '0;
    if (irqent) g = 1'b0;
    if (d == 16) begin
      ov = 1'b1;
`ifdef STACK_CTRL_TRAP_EN
      e.pcn = 11'h7FF;
      g     = 1'b0;
`else
      e.push = 1'b1;
      e.data = val;
      e.pcn  = tgt;
`endif
    end else begin
      d++;
      e.push = 1'b1;
      e.data = val;
      e.pcn  = tgt;
    end
    e.depth = 5'(d);
    e.gie   = g;
    e.ovf   = ov;
    e.udf   = un;
    q.push_back(e);
  endtask

  task automatic m_pop(input logic [10:0] top, input logic rfie);
    exp_t e;
    e = '0;
    if (rfie) g = 1'b1;
    if (d == 0) begin
      un = 1'b1;
`ifdef STACK_CTRL_TRAP_EN
      e.pcn = 11'h7FF;
      g     = 1'b0;
`else
      e.pop = 1'b1;
      e.pcn = top;
`endif
    end else begin
      d--;
      e.pop = 1'b1;
      e.pcn = top;
    end
    e.depth = 5'(d);
    e.gie   = g;
    e.ovf   = ov;
    e.udf   = un;
    q.push_back(e);
  endtask

  task automatic ev_call(input logic [10:0] pc, input logic [10:0] tgt);
    bus.call_req    = 1'b1;
    bus.pc_cur      = pc;
    bus.call_target = tgt;
    cyc();
    clr_in();
    cyc();
  endtask

  task automatic ev_ret(input logic [10:0] top, input logic rfie);
    bus.ret_req    = ~rfie;
    bus.retfie_req = rfie;
    bus.stack_top  = top;
    cyc();
    clr_in();
    cyc();
  endtask

  // Monitor: every redirect must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t act;
    exp_t e;
    if (reset) begin
      act = {bus.stk_push, bus.stk_pop, bus.stk_data, bus.pc_next,
             bus.depth, bus.gie, bus.overflow, bus.underflow};
      if (bus.pc_load) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_redirect act=%h exp=none", act);
        end else begin
          e = q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL redirect act=%h exp=%h", act, e);
          end
        end
        n_chk++;
        if (bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_with_load act=%b exp=1", bus.busy);
        end
      end else if (bus.stk_push || bus.stk_pop || bus.busy) begin
        n_chk++;
        n_fail++;
        $display("FAIL stray_strobe act=%b%b%b exp=000",
                 bus.stk_push, bus.stk_pop, bus.busy);
      end
    end
  end

  initial begin
    clr_in();
    bus.pc_cur      = '0;
    bus.call_target = '0;
    bus.stack_top   = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) cyc();
    chk("rst_strobes", {bus.stk_push, bus.stk_pop, bus.pc_load,
        bus.busy, bus.overflow, bus.underflow}, 0);
    chk("rst_data", {bus.stk_data, bus.pc_next}, 0);
    chk("rst_depth", bus.depth, 0);
    chk("rst_gie", bus.gie, 0);

    // CALL 010 -> 200
    m_push(11'h011, 11'h200, 1'b0);
    bus.call_req    = 1'b1;
    bus.pc_cur      = 11'h010;
    bus.call_target = 11'h200;
    cyc();
    chk("call_busy", bus.busy, 1);
    chk("call_depth", bus.depth, 1);
    clr_in();
    cyc();
    chk("call_busy_done", bus.busy, 0);

    // RETURN, with a CALL presented during FLUSH
    m_pop(11'h011, 1'b0);
    bus.ret_req   = 1'b1;
    bus.stack_top = 11'h011;
    cyc();
    clr_in();
    bus.call_req = 1'b1;
    cyc();
    clr_in();
    cyc();
    chk("ret_depth", bus.depth, 0);

    // stall blocks acceptance
    bus.stall    = 1'b1;
    bus.call_req = 1'b1;
    repeat (2) cyc();
    clr_in();
    cyc();
    chk("stall_depth", bus.depth, 0);

    // GIE write, then irq beats CALL
    bus.gie_wr    = 1'b1;
    bus.gie_wdata = 1'b1;
    cyc();
    clr_in();
    g = 1'b1;
    chk("gie_write", bus.gie, 1);
    m_push(11'h050, 11'h004, 1'b1);
    bus.irq         = 1'b1;
    bus.call_req    = 1'b1;
    bus.pc_cur      = 11'h050;
    bus.call_target = 11'h300;
    cyc();
    bus.call_req = 1'b0;
    repeat (2) cyc();
    bus.irq = 1'b0;
    cyc();
    chk("irq_gie_clear", bus.gie, 0);
    chk("irq_depth", bus.depth, 1);

    // RETFIE beats a same-cycle software GIE clear
    m_pop(11'h050, 1'b1);
    bus.gie_wr    = 1'b1;
    bus.gie_wdata = 1'b0;
    ev_ret(11'h050, 1'b1);
    chk("retfie_gie", bus.gie, 1);

    // 17 CALLs: saturate and overflow
    for (int i = 0; i < 17; i++) begin
      m_push(11'(i + 1), 11'(11'h100 + i), 1'b0);
      ev_call(11'(i), 11'(11'h100 + i));
    end
    chk("ovf_set", bus.overflow, 1);
    chk("ovf_depth", bus.depth, 16);
    bus.clr_flags = 1'b1;
    cyc();
    clr_in();
    ov = 1'b0;
    chk("ovf_clr", bus.overflow, 0);

    // fault wins over clr_flags in the same cycle
    m_push(11'h021, 11'h222, 1'b0);
    bus.clr_flags = 1'b1;
    ev_call(11'h020, 11'h222);
    chk("ovf_vs_clr", bus.overflow, 1);
    bus.clr_flags = 1'b1;
    cyc();
    clr_in();
    ov = 1'b0;

    // drain, then underflow
    for (int i = 0; i < 16; i++) begin
      m_pop(11'(11'h180 + i), 1'b0);
      ev_ret(11'(11'h180 + i), 1'b0);
    end
    chk("drain_depth", bus.depth, 0);
    m_pop(11'h3AB, 1'b0);
    ev_ret(11'h3AB, 1'b0);
    chk("udf_set", bus.underflow, 1);
    chk("udf_depth", bus.depth, 0);

    // async reset during FLUSH
    m_push(11'h021, 11'h040, 1'b0);
    bus.call_req    = 1'b1;
    bus.pc_cur      = 11'h020;
    bus.call_target = 11'h040;
    cyc();
    clr_in();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_strobes", {bus.stk_push, bus.stk_pop, bus.pc_load,
        bus.busy, bus.overflow, bus.underflow, bus.gie}, 0);
    chk("async_rst_data", {bus.stk_data, bus.pc_next, bus.depth}, 0);
    d = 0; g = 1'b0; ov = 1'b0; un = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
    repeat (3) cyc();
    chk("post_rst_depth", bus.depth, 0);
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/call_return_ctrl.md
Name: call_return_ctrl

Overview:
- Sequencer for the 16-entry, 11-bit hardware return-address stack in the MCU core.
- Arbitrates CALL, RETURN/RETLW, RETFIE and interrupt entry, and drives the stack's push/pop/data inputs.
- Produces the PC redirect, tracks depth, owns the global interrupt enable (GIE), and flags overflow/underflow.
- Sits between the instruction decoder and the PC/stack datapath.

Parameters:
- ADDR_W, 11, program-counter / stack entry width.
- DEPTH, 16, number of stack entries; must be a power of two.
- INT_VECTOR, 11'h004, interrupt entry address.
- TRAP_VECTOR, 11'h7FF, stack-fault target; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_cur  in  ADDR_W  address of the instruction now in decode.
- call_req  in  1  decoded CALL.
- call_target  in  ADDR_W  CALL destination.
- ret_req  in  1  decoded RETURN/RETLW.
- retfie_req  in  1  decoded RETFIE.
- irq  in  1  level interrupt request.
- stall  in  1  pipeline hold; while high no request is accepted.
- gie_wr  in  1  software write strobe for GIE.
- gie_wdata  in  1  GIE write value.
- clr_flags  in  1  clears the sticky fault flags.
- stack_top  in  ADDR_W  stack read port (current top entry).
- stk_push  out  1  push strobe to the stack.
- stk_pop  out  1  pop strobe to the stack.
- stk_data  out  ADDR_W  push data.
- pc_load  out  1  PC redirect strobe.
- pc_next  out  ADDR_W  redirect address.
- gie  out  1  global interrupt enable.
- depth  out  log2(DEPTH)+1  live entry count, 0..DEPTH.
- overflow  out  1  sticky: push issued at depth==DEPTH.
- underflow  out  1  sticky: pop issued at depth==0.
- busy  out  1  controller in a flush cycle.

Behaviour:
- Reset (reset==0, asynchronous): all outputs 0, depth=0, gie=0, overflow=underflow=0, state=IDLE.
- FSM states: IDLE and FLUSH.
- IDLE: accepts one event per cycle when stall==0. Priority: irq&gie > call_req > retfie_req > ret_req. Lower-priority requests in the same cycle are dropped.
- Interrupt entry: push pc_cur (the interrupted instruction is re-executed), pc_next=INT_VECTOR, gie<=0, go to FLUSH.
- CALL: push pc_cur+1 (modulo 2^ADDR_W), pc_next=call_target, go to FLUSH.
- RETURN: pop, pc_next=stack_top sampled in the request cycle, go to FLUSH.
- RETFIE: same as RETURN, plus gie<=1.
- All outputs are registered: stk_push/stk_pop/stk_data/pc_load/pc_next are asserted for exactly one cycle, in the cycle after acceptance.
- FLUSH: lasts exactly 1 cycle; busy=1; all requests are ignored (the decoder discards its fetched slot); then return to IDLE.
- depth: +1 on push when depth<DEPTH; -1 on pop when depth>0. Updated in the same edge that registers the strobe.
- Overflow (push at depth==DEPTH): push is still issued (the stack wraps and overwrites the oldest entry); depth holds at DEPTH; overflow<=1.
- Underflow (pop at depth==0): pop is still issued; pc_next=stack_top (undefined contents); depth holds at 0; underflow<=1.
- Fault flags are sticky: cleared only by clr_flags or reset. A fault set in the same cycle as clr_flags wins (flag ends at 1).
- GIE: gie_wr loads gie_wdata. In the same cycle, an interrupt-entry clear or a RETFIE set overrides gie_wr.
- irq is level-sensitive. Another entry can only be accepted after FLUSH, and requires gie to be set again.
- stall==1 in IDLE: no action, state held. stall is ignored in FLUSH.
- reset asserted mid-FLUSH: immediate return to reset values; no further strobes.

Optional Feature:
- Macro: STACK_CTRL_TRAP_EN.
- Defined: a push at depth==DEPTH or a pop at depth==0 is suppressed (no stk_push/stk_pop). Instead pc_load=1 and pc_next=TRAP_VECTOR, depth is unchanged, the flag is set as normal, and gie<=0. The FSM still goes to FLUSH.
- Not defined: wrap/garbage-return behaviour exactly as in Behaviour, and TRAP_VECTOR is unused.

Test Plan:
- Reset released, idle 5 cycles -> all outputs 0, depth=0, gie=0.
- call_req with pc_cur=11'h010, call_target=11'h200 -> next cycle stk_push=1, stk_data=11'h011, pc_load=1, pc_next=11'h200, depth=1; busy=1 for 1 cycle.
- Then ret_req with stack_top=11'h011 -> next cycle stk_pop=1, pc_next=11'h011, depth=0; a call_req during FLUSH is ignored.
- gie_wr=1/gie_wdata=1, then irq=1 together with call_req at pc_cur=11'h050 -> push 11'h050, pc_next=11'h004, gie=0, CALL dropped. Then retfie_req -> pop, gie=1.
- 17 consecutive CALLs -> depth saturates at 16 and overflow=1 after the 17th; then clr_flags -> overflow=0. Repeat with STACK_CTRL_TRAP_EN defined -> 17th CALL gives no stk_push and pc_next=11'h7FF.
- ret_req at depth=0 -> stk_pop=1, underflow=1, depth stays 0. Assert reset low mid-FLUSH -> outputs 0 asynchronously, before the next clock edge.
